// File: rtl/fcs_arb_pkg.sv
// Shared definitions for the FCS-checker arbiter: ingress FSM encoding and default parameters.
package fcs_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } arb_state_t;

  localparam int unsigned DEF_PORTS         = 4;
  localparam int unsigned DEF_ID_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CNT_WIDTH     = 16;

endpackage

// File: rtl/fcs_arb_id_fifo.sv
// Small synchronous FIFO of port IDs; pointers carry one extra wrap bit to tell full from empty.
module fcs_arb_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so push-while-full is fine alongside it.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/axis_eth_fcs_arb_64.sv
// Frame-level round-robin arbiter sharing one 64-bit FCS checker, with tdest tagging and
// per-port saturating bad-frame counters. Define FCS_ARB_GOOD_CNT_EN to add good_cnt.
module axis_eth_fcs_arb_64
  import fcs_arb_pkg::*;
#(
  parameter int unsigned PORTS         = DEF_PORTS,
  parameter int unsigned ID_WIDTH      = $clog2(PORTS),
  parameter int unsigned ID_FIFO_DEPTH = DEF_ID_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS*64-1:0]        s_axis_tdata,
  input  logic [PORTS*8-1:0]         s_axis_tkeep,
  input  logic [PORTS-1:0]           s_axis_tvalid,
  output logic [PORTS-1:0]           s_axis_tready,
  input  logic [PORTS-1:0]           s_axis_tlast,
  input  logic [PORTS-1:0]           s_axis_tuser,
  output logic [63:0]                chk_s_axis_tdata,
  output logic [7:0]                 chk_s_axis_tkeep,
  output logic                       chk_s_axis_tvalid,
  output logic                       chk_s_axis_tlast,
  output logic                       chk_s_axis_tuser,
  input  logic                       chk_s_axis_tready,
  input  logic [63:0]                chk_m_axis_tdata,
  input  logic [7:0]                 chk_m_axis_tkeep,
  input  logic                       chk_m_axis_tvalid,
  input  logic                       chk_m_axis_tlast,
  input  logic                       chk_m_axis_tuser,
  output logic                       chk_m_axis_tready,
  output logic [63:0]                m_axis_tdata,
  output logic [7:0]                 m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic [ID_WIDTH-1:0]        m_axis_tdest,
  input  logic                       m_axis_tready,
  output logic [PORTS*CNT_WIDTH-1:0] bad_fcs_cnt,
`ifdef FCS_ARB_GOOD_CNT_EN
  output logic [PORTS*CNT_WIDTH-1:0] good_cnt,
`endif
  output logic                       busy
);

  arb_state_t          state;
  logic [ID_WIDTH-1:0] sel;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] req_sel;
  logic [ID_WIDTH-1:0] cand;
  logic                req_any;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ID_WIDTH-1:0] fifo_head;

  logic [63:0] in_data [PORTS];
  logic [7:0]  in_keep [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign in_data[i] = s_axis_tdata[i*64 +: 64];
    assign in_keep[i] = s_axis_tkeep[i*8 +: 8];
  end

  // Walk from the far end back towards rr_ptr so the nearest requester wins.
  always_comb begin
    req_any = 1'b0;
    req_sel = '0;
    cand    = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % int'(PORTS));
      if (s_axis_tvalid[cand]) begin
        req_any = 1'b1;
        req_sel = cand;
      end
    end
  end

  assign fifo_push = (state == ST_IDLE) && req_any && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_push) begin
            sel   <= req_sel;
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (chk_s_axis_tvalid && chk_s_axis_tready && chk_s_axis_tlast) begin
            rr_ptr <= (sel == ID_WIDTH'(PORTS - 1)) ? '0 : sel + ID_WIDTH'(1);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_tready     = '0;
    chk_s_axis_tdata  = in_data[sel];
    chk_s_axis_tkeep  = in_keep[sel];
    chk_s_axis_tlast  = s_axis_tlast[sel];
    chk_s_axis_tuser  = s_axis_tuser[sel];
    chk_s_axis_tvalid = 1'b0;
    if (state == ST_ACTIVE) begin
      chk_s_axis_tvalid  = s_axis_tvalid[sel];
      s_axis_tready[sel] = chk_s_axis_tready;
    end
  end

  fcs_arb_id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (req_sel),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output beats are only released while an ID is queued to tag them with.
  assign m_axis_tdata      = chk_m_axis_tdata;
  assign m_axis_tkeep      = chk_m_axis_tkeep;
  assign m_axis_tlast      = chk_m_axis_tlast;
  assign m_axis_tuser      = chk_m_axis_tuser;
  assign m_axis_tvalid     = chk_m_axis_tvalid && !fifo_empty;
  assign chk_m_axis_tready = m_axis_tready && !fifo_empty;
  assign m_axis_tdest      = fifo_head;
  assign fifo_pop          = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign busy              = (state == ST_ACTIVE) || !fifo_empty;

  for (genvar i = 0; i < PORTS; i++) begin : g_cnt
    logic                 hit;
    logic [CNT_WIDTH-1:0] bad_q;

    assign hit = fifo_pop && (fifo_head == ID_WIDTH'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        bad_q <= '0;
      end else if (hit && m_axis_tuser && (bad_q != '1)) begin
        bad_q <= bad_q + CNT_WIDTH'(1);
      end
    end

    assign bad_fcs_cnt[i*CNT_WIDTH +: CNT_WIDTH] = bad_q;

`ifdef FCS_ARB_GOOD_CNT_EN
    logic [CNT_WIDTH-1:0] good_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        good_q <= '0;
      end else if (hit && !m_axis_tuser && (good_q != '1)) begin
        good_q <= good_q + CNT_WIDTH'(1);
      end
    end

    assign good_cnt[i*CNT_WIDTH +: CNT_WIDTH] = good_q;
`endif
  end

endmodule

// File: tb/tb_axis_eth_fcs_arb_64.sv
// Scoreboard bench: per-port expected beat queues, a behavioural checker stand-in, directed
// scenarios followed by randomized traffic with ready stalls.
`timescale 1ns/1ps
module tb_axis_eth_fcs_arb_64;

  localparam int PORTS = 4;
  localparam int IDW   = 2;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [PORTS*64-1:0]   s_axis_tdata;
  logic [PORTS*8-1:0]    s_axis_tkeep;
  logic [PORTS-1:0]      s_axis_tvalid;
  logic [PORTS-1:0]      s_axis_tready;
  logic [PORTS-1:0]      s_axis_tlast;
  logic [PORTS-1:0]      s_axis_tuser;
  logic [63:0]           chk_s_axis_tdata;
  logic [7:0]            chk_s_axis_tkeep;
  logic                  chk_s_axis_tvalid;
  logic                  chk_s_axis_tlast;
  logic                  chk_s_axis_tuser;
  logic                  chk_s_axis_tready;
  logic [63:0]           chk_m_axis_tdata;
  logic [7:0]            chk_m_axis_tkeep;
  logic                  chk_m_axis_tvalid;
  logic                  chk_m_axis_tlast;
  logic                  chk_m_axis_tuser;
  logic                  chk_m_axis_tready;
  logic [63:0]           m_axis_tdata;
  logic [7:0]            m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;
  logic [IDW-1:0]        m_axis_tdest;
  logic                  m_axis_tready;
  logic [PORTS*CW-1:0]   bad_fcs_cnt;
`ifdef FCS_ARB_GOOD_CNT_EN
  logic [PORTS*CW-1:0]   good_cnt;
`endif
  logic                  busy;

  axis_eth_fcs_arb_64 #(
    .PORTS         (PORTS),
    .ID_WIDTH      (IDW),
    .ID_FIFO_DEPTH (4),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .chk_s_axis_tdata  (chk_s_axis_tdata),
    .chk_s_axis_tkeep  (chk_s_axis_tkeep),
    .chk_s_axis_tvalid (chk_s_axis_tvalid),
    .chk_s_axis_tlast  (chk_s_axis_tlast),
    .chk_s_axis_tuser  (chk_s_axis_tuser),
    .chk_s_axis_tready (chk_s_axis_tready),
    .chk_m_axis_tdata  (chk_m_axis_tdata),
    .chk_m_axis_tkeep  (chk_m_axis_tkeep),
    .chk_m_axis_tvalid (chk_m_axis_tvalid),
    .chk_m_axis_tlast  (chk_m_axis_tlast),
    .chk_m_axis_tuser  (chk_m_axis_tuser),
    .chk_m_axis_tready (chk_m_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tdest      (m_axis_tdest),
    .m_axis_tready     (m_axis_tready),
    .bad_fcs_cnt       (bad_fcs_cnt),
`ifdef FCS_ARB_GOOD_CNT_EN
    .good_cnt          (good_cnt),
`endif
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    in_cnt = 0;
  bit    stall_en = 1'b0;
  bit    hold_m = 1'b0;
  bit    cnt_pending = 1'b0;
  beat_t src_q [PORTS][$];
  beat_t exp_q [PORTS][$];
  beat_t stub_q[$];
  int    stub_t[$];
  int    order_q[$];
  int    bad_model [PORTS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int p, input int n, input bit bad, input logic [7:0] lkeep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == n - 1);
      b.keep = b.last ? lkeep : 8'hFF;
      b.user = b.last && bad;
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  function automatic logic [PORTS*CW-1:0] model_vec();
    logic [PORTS*CW-1:0] v;
    for (int p = 0; p < PORTS; p++) v[p*CW +: CW] = CW'(bad_model[p]);
    return v;
  endfunction

  function automatic int order_code();
    int c = order_q.size();
    foreach (order_q[i]) c = c * 10 + order_q[i];
    return c;
  endfunction

  function automatic bit all_empty();
    bit e = (stub_q.size() == 0);
    for (int p = 0; p < PORTS; p++) e = e && (src_q[p].size() == 0) && (exp_q[p].size() == 0);
    return e;
  endfunction

  task automatic drain();
    int t = 0;
    while (t < 3000 && !all_empty()) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("drain_complete", all_empty(), 1);
    check("drain_not_busy", busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Upstream sources: one beat per port presented while its queue is non-empty.
  initial begin : driver
    bit acc [PORTS];
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < PORTS; p++) acc[p] = s_axis_tvalid[p] && s_axis_tready[p];
      @(posedge clk);
      #1;
      for (int p = 0; p < PORTS; p++) begin
        if (rst) src_q[p].delete();
        else if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          s_axis_tvalid[p]         = 1'b1;
          s_axis_tdata[p*64 +: 64] = src_q[p][0].data;
          s_axis_tkeep[p*8 +: 8]   = src_q[p][0].keep;
          s_axis_tlast[p]          = src_q[p][0].last;
          s_axis_tuser[p]          = src_q[p][0].user;
        end else begin
          s_axis_tvalid[p] = 1'b0;
          s_axis_tlast[p]  = 1'b0;
          s_axis_tuser[p]  = 1'b0;
        end
      end
      m_axis_tready = hold_m ? 1'b0 : (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Checker stand-in: in-order pass-through with at least one cycle of latency; tuser is the verdict.
  initial begin : checker_stub
    bit    in_hs;
    bit    out_hs;
    beat_t in_b;
    chk_s_axis_tready = 1'b0;
    chk_m_axis_tvalid = 1'b0;
    chk_m_axis_tdata  = '0;
    chk_m_axis_tkeep  = '0;
    chk_m_axis_tlast  = 1'b0;
    chk_m_axis_tuser  = 1'b0;
    forever begin
      @(negedge clk);
      in_hs  = chk_s_axis_tvalid && chk_s_axis_tready;
      in_b   = {chk_s_axis_tdata, chk_s_axis_tkeep, chk_s_axis_tlast, chk_s_axis_tuser};
      out_hs = chk_m_axis_tvalid && chk_m_axis_tready;
      @(posedge clk);
      #1;
      if (rst) begin
        stub_q.delete();
        stub_t.delete();
      end else begin
        if (out_hs && stub_q.size() > 0) begin
          void'(stub_q.pop_front());
          void'(stub_t.pop_front());
        end
        if (in_hs) begin
          stub_q.push_back(in_b);
          stub_t.push_back(cyc + (stall_en ? int'($urandom_range(0, 2)) : 0));
          in_cnt++;
        end
      end
      chk_s_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stub_q.size() > 0 && stub_t[0] <= cyc) begin
        chk_m_axis_tvalid = 1'b1;
        chk_m_axis_tdata  = stub_q[0].data;
        chk_m_axis_tkeep  = stub_q[0].keep;
        chk_m_axis_tlast  = stub_q[0].last;
        chk_m_axis_tuser  = stub_q[0].user;
      end else begin
        chk_m_axis_tvalid = 1'b0;
        chk_m_axis_tlast  = 1'b0;
        chk_m_axis_tuser  = 1'b0;
      end
    end
  end

  // Monitor: each output beat must be the next beat issued on the port named by tdest.
  initial begin : monitor
    beat_t got;
    beat_t e;
    int    d;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int p = 0; p < PORTS; p++) begin
          exp_q[p].delete();
          bad_model[p] = 0;
        end
        cnt_pending = 1'b0;
        continue;
      end
      if (cnt_pending) begin
        check("bad_fcs_cnt_after_frame", bad_fcs_cnt, model_vec());
        cnt_pending = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        d   = int'(m_axis_tdest);
        if (exp_q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got beat %0h on tdest %0d, expected no beat", got, d);
        end else begin
          e = exp_q[d].pop_front();
          check("output_beat", got, e);
          if (e.last) begin
            if (e.user && bad_model[d] < CMAX) bad_model[d]++;
            cnt_pending = 1'b1;
            order_q.push_back(d);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          base;
    int          t;
    logic [7:0]  lk;
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_chk_s_tvalid", chk_s_axis_tvalid, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_counters", bad_fcs_cnt, 0);
    rst = 1'b0;

    // Single 3-beat frame on port 2: one bubble, then pass-through.
    @(negedge clk);
    order_q.delete();
    send(2, 3, 1'b0, 8'h0F);
    @(negedge clk);
    check("t1_bubble_chk_valid", chk_s_axis_tvalid, 0);
    check("t1_bubble_ready", s_axis_tready, 0);
    @(negedge clk);
    check("t1_chk_valid", chk_s_axis_tvalid, 1);
    check("t1_ready_port2", s_axis_tready, 4'b0100);
    check("t1_busy", busy, 1);
    drain();
    check("t1_tdest", order_code(), 12);
    check("t1_bad_cnt2", bad_fcs_cnt[2*CW +: CW], 0);

    // Ports 0,1,3 contend from rr_ptr 0, then 1 and 3 contend from the wrapped pointer.
    pulse_reset();
    order_q.delete();
    send(0, 2, 1'b0, 8'hFF);
    send(1, 2, 1'b0, 8'hFF);
    send(3, 2, 1'b0, 8'hFF);
    drain();
    check("t2_order_0_1_3", order_code(), 3013);
    order_q.delete();
    send(1, 2, 1'b0, 8'hFF);
    send(3, 2, 1'b0, 8'hFF);
    drain();
    check("t2_rr_wrapped_order", order_code(), 213);

    // Bad FCS on port 1.
    send(1, 3, 1'b1, 8'h03);
    drain();
    check("t3_bad_cnt1", bad_fcs_cnt[1*CW +: CW], 1);

    // Output stalled: only ID_FIFO_DEPTH frames may enter the checker.
    hold_m = 1'b1;
    base = in_cnt;
    order_q.delete();
    repeat (5) send(0, 1, 1'b0, 8'hFF);
    repeat (30) @(negedge clk);
    check("t4_frames_accepted", in_cnt - base, 4);
    check("t4_fifth_waiting", src_q[0].size(), 1);
    check("t4_ready0_low", s_axis_tready[0], 0);
    check("t4_busy", busy, 1);
    hold_m = 1'b0;
    drain();
    check("t4_all_tdest0", order_code(), 500000);

    // Saturation of the narrow counter on port 3.
    for (int i = 0; i < 5; i++) send(3, int'($urandom_range(1, 3)), 1'b1, 8'h01);
    drain();
    check("t5_bad_cnt3_sat", bad_fcs_cnt[3*CW +: CW], CMAX);

    // Reset in the middle of a port-2 frame.
    send(2, 6, 1'b0, 8'hFF);
    t = 0;
    while (t < 50 && !(s_axis_tvalid[2] && s_axis_tready[2])) begin
      @(negedge clk);
      t++;
    end
    check("t6_frame_started", t < 50, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_readies", s_axis_tready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_counters", bad_fcs_cnt, 0);
    check("t6_rst_chk_valid", chk_s_axis_tvalid, 0);
    rst = 1'b0;
    order_q.delete();
    send(2, 2, 1'b0, 8'hFF);
    send(0, 2, 1'b0, 8'hFF);
    drain();
    check("t6_first_grant_port0", order_code(), 202);

    // Randomized traffic with stalls on every interface.
    stall_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      lk = 8'hFF >> $urandom_range(0, 7);
      send(int'($urandom_range(0, PORTS - 1)), int'($urandom_range(1, 4)),
           $urandom_range(0, 2) == 0, lk);
    end
    drain();
    stall_en = 1'b0;
    repeat (5) @(negedge clk);
    check("final_counters", bad_fcs_cnt, model_vec());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
